// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and defaults for the UART transmit arbiter
// Contents:
//   uart_byte_t            one UART payload byte
//   txarb_state_e          arbiter FSM states
//   DEFAULT_BUSY_TIMEOUT   default wait for tx_busy to rise after a send strobe
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } txarb_state_e;

    localparam int DEFAULT_BUSY_TIMEOUT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
// Signals:
//   req_valid  [NUM_REQ]    requester i has a byte pending
//   req_data   [NUM_REQ*8]  byte of requester i at [8*i+7:8*i]
//   req_ready  [NUM_REQ]    one-hot accept pulse
//   tx_din     [8]          byte presented to the transmitter
//   tx_send                 one-cycle start strobe to the transmitter
//   tx_busy                 transmitter frame in progress
// Modports:
//   master  arbiter side (drives req_ready, tx_din, tx_send)
//   slave   environment side (requesters and transmitter)
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    uart_byte_t           tx_din;
    logic                 tx_send;
    logic                 tx_busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_din,
        output tx_send
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_din,
        input  tx_send
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - combinational round-robin pick
// Ports:
//   req     in   N    request vector
//   ptr     in   IW   highest-priority index for this pick
//   onehot  out  N    selected request, one-hot (all zero when none)
//   idx     out  IW   index of selected request (0 when none)
//   any     out  1    at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // N need not be a power of two, so wrap explicitly instead of relying on overflow.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Scan from ptr upward; the first request found wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int off = 0; off < N; off++) begin
            cand = wrap_add(ptr, off);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between NUM_REQ byte producers
// Optional feature macro: TXARB_TIMEOUT_EN (busy-rise timeout with sticky timeout_err).
// Ports:
//   clk          in   1          system clock, rising edge
//   reset_n      in   1          asynchronous active-low reset
//   bus          master modport of uart_tx_arbiter_if (requesters + transmitter)
//   grant_id     out  IW         index of current/last granted requester
//   active       out  1          high from accept until the frame completes
//   timeout_err  out  1          sticky busy-never-rose flag (0 without TXARB_TIMEOUT_EN)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_tx_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    txarb_state_e  state;
    txarb_state_e  state_nxt;
    logic [IW-1:0] ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    uart_byte_t    pick_byte;
    uart_byte_t    din_q;
    logic          to_hit;

    // Arbitration runs on the live request vector, so a request withdrawn
    // before the GRANT edge simply is not picked.
    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // A busy transmitter in IDLE belongs to someone else (or to a frame
            // started before reset); wait it out before granting.
            IDLE:      if (!bus.tx_busy && (|bus.req_valid)) state_nxt = GRANT;
            GRANT:     state_nxt = pick_any ? SEND : IDLE;
            SEND:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.tx_send   = 1'b0;
        if (state == GRANT) begin
            bus.req_ready = pick_onehot;
        end
        if (state == SEND) begin
            bus.tx_send = 1'b1;
        end
    end

    // Byte, grant index and pointer are captured on the accept edge and held
    // until the next accept, so tx_din stays stable for the whole frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q    <= '0;
            grant_id <= '0;
            active   <= 1'b0;
            ptr      <= '0;
        end else begin
            if (state == GRANT && pick_any) begin
                din_q    <= pick_byte;
                grant_id <= pick_idx;
                active   <= 1'b1;
                ptr      <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end else if ((state == WAIT_DONE && !bus.tx_busy) || to_hit) begin
                active <= 1'b0;
            end
        end
    end

    assign bus.tx_din = din_q;

`ifdef TXARB_TIMEOUT_EN
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_err_q;

    // Counter idles at zero outside WAIT_BUSY, so every WAIT_BUSY visit starts fresh.
    assign to_hit = (state == WAIT_BUSY) && !bus.tx_busy &&
                    (to_cnt == TW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state != WAIT_BUSY) begin
                to_cnt <= '0;
            end else if (!bus.tx_busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_hit) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = to_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] grant_id;
    logic       active;
    logic       timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // requester model
    logic [N-1:0] vld;
    logic [N-1:0] keep;
    logic [7:0]   dat [N];
    int           gen_left [N];
    bit           rand_on;
    int           acc_new, acc_old;
    // arbitration reference
    int           mptr;
    bit           pend;
    int           since_grant;
    logic [7:0]   exp_byte;
    int           exp_id;
    int           n_grants, n_sent;
    logic [7:0]   sent_log [256];
    int           cyc, ready_cyc, send_cyc, fall_cyc;
    // transmitter model
    logic         busy;
    int           busy_left, rise_at, frame_len;
    bit           own_frame, tx_dead, rand_frame;
    logic [7:0]   frame_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first valid index at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        for (int o = 0; o < N; o++) begin
            r = v >> ((p + o) % N);
            if (r[0]) return (p + o) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = vld;
        for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = dat[i];
        bus.tx_busy = busy;
    endtask

    task automatic step();
        logic [N-1:0] s_ready;
        logic         s_send;
        logic [7:0]   s_din;
        int           e;
        @(negedge clk);
        cyc++;
        s_ready = bus.req_ready;
        s_send  = bus.tx_send;
        s_din   = bus.tx_din;
        e       = -1;
        check("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        if (s_ready != '0) begin
            e = rr_pick(vld, mptr);
            check("ready_grant", 32'(s_ready), (e < 0) ? 32'hDEAD : 32'(1 << e));
            if (e >= 0) begin
                exp_byte = dat[e];
                exp_id   = e;
                mptr     = (e + 1) % N;
                acc_new  = e;
            end
            pend        = 1'b1;
            since_grant = 0;
            ready_cyc   = cyc;
            n_grants++;
        end else if (pend) begin
            since_grant++;
        end
        if (s_send) begin
            check("send_after_grant", 32'(pend), 32'd1);
            check("send_latency", since_grant, 1);
            check("tx_din", s_din, exp_byte);
            check("grant_id", grant_id, exp_id);
            check("active_at_send", active, 1);
            check("send_while_busy", busy, 0);
            if (n_sent < 256) sent_log[n_sent] = s_din;
            n_sent++;
            pend       = 1'b0;
            send_cyc   = cyc;
            frame_byte = s_din;
            if (!tx_dead) rise_at = cyc + 1;
        end
        if (own_frame && busy) check("din_stable", s_din, frame_byte);
        // transmitter: busy rises the cycle after it samples send
        if (rise_at == cyc) begin
            busy      = 1'b1;
            own_frame = 1'b1;
            busy_left = rand_frame ? int'($urandom_range(12, 2)) : frame_len;
        end else if (busy && busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                busy      = 1'b0;
                own_frame = 1'b0;
                fall_cyc  = cyc;
            end
        end
        // requesters: the accepted byte leaves one cycle after the accept edge
        if (acc_old >= 0 && !keep[acc_old]) vld[acc_old] = 1'b0;
        acc_old = acc_new;
        acc_new = -1;
        if (rand_on) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && gen_left[i] > 0 && $urandom_range(3) == 0) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                    gen_left[i]--;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset(input bit keep_tx);
        reset_n   = 1'b0;
        vld       = '0;
        keep      = '0;
        pend      = 1'b0;
        acc_new   = -1;
        acc_old   = -1;
        mptr      = 0;
        own_frame = 1'b0;
        if (!keep_tx) begin
            busy      = 1'b0;
            busy_left = 0;
            rise_at   = -1;
        end
        drive();
    endtask

    task automatic run_until_sent(input int target, input int budget, input string tag);
        int k = 0;
        while (n_sent < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_budget"}, 32'(n_sent >= target), 32'd1);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int k = 0;
        while ((active || busy || vld != '0 || rise_at > cyc) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_idle_budget"}, 32'(k < budget), 32'd1);
    endtask

    logic [7:0] rr_exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    int base, g0, t0, k, left;

    initial begin
        cyc = 0; n_grants = 0; n_sent = 0; ready_cyc = 0; send_cyc = 0; fall_cyc = 0;
        frame_len = 10; tx_dead = 1'b0; rand_frame = 1'b0; rand_on = 1'b0;
        since_grant = 0; exp_byte = '0; exp_id = 0; frame_byte = '0;
        for (int i = 0; i < N; i++) begin dat[i] = '0; gen_left[i] = 0; end
        do_reset(1'b0);
        repeat (3) step();

        // reset values
        check("rst_ready", bus.req_ready, 0);
        check("rst_din", bus.tx_din, 0);
        check("rst_send", bus.tx_send, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;
        step();

        // single requester
        vld[1] = 1'b1; dat[1] = 8'hA5; drive(); t0 = cyc;
        run_until_sent(1, 20, "single");
        check("single_ready_cyc", ready_cyc - t0, 1);
        check("single_latency", send_cyc - t0, 2);
        check("single_byte", sent_log[0], 8'hA5);
        run_until_idle(40, "single");
        check("single_grants", n_grants, 1);
        check("single_active_off", active, 0);

        // all requesters valid continuously from pointer 0
        do_reset(1'b0); repeat (2) step(); reset_n = 1'b1; step();
        base = n_sent; g0 = n_grants;
        keep = '1; vld = '1;
        for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
        drive();
        run_until_sent(base + 5, 200, "rr_all");
        check("rr_gap_after_fall", send_cyc - fall_cyc, 3);
        vld = '0; keep = '0; drive();
        for (int i = 0; i < 5; i++) check("rr_order", sent_log[base + i], rr_exp[i]);
        check("rr_pulse_per_frame", n_grants - g0, 5);
        run_until_idle(60, "rr_all");

        // pointer wrap: grant 3, then 0 and 2 compete
        base = n_sent;
        vld[3] = 1'b1; dat[3] = 8'h33; drive();
        run_until_sent(base + 1, 30, "wrap3");
        vld[0] = 1'b1; dat[0] = 8'h40; vld[2] = 1'b1; dat[2] = 8'h42; drive();
        run_until_sent(base + 3, 80, "wrap02");
        check("wrap_first", sent_log[base], 8'h33);
        check("wrap_second", sent_log[base + 1], 8'h40);
        check("wrap_third", sent_log[base + 2], 8'h42);
        run_until_idle(40, "wrap");

        // transmitter busy with a foreign frame at reset release
        do_reset(1'b0);
        busy = 1'b1; busy_left = 8; drive();
        step(); reset_n = 1'b1;
        base = n_sent;
        vld[0] = 1'b1; dat[0] = 8'h77; drive();
        run_until_sent(base + 1, 40, "busy_rst");
        check("busy_rst_byte", sent_log[base], 8'h77);
        check("busy_rst_after_fall", send_cyc - fall_cyc, 2);
        run_until_idle(40, "busy_rst");

        // reset during WAIT_DONE; the transmitter keeps going
        base = n_sent;
        vld[2] = 1'b1; dat[2] = 8'h5C; drive();
        run_until_sent(base + 1, 30, "mid");
        repeat (3) step();
        check("mid_active", active, 1);
        do_reset(1'b1);
        #1;
        check("mid_rst_ready", bus.req_ready, 0);
        check("mid_rst_din", bus.tx_din, 0);
        check("mid_rst_send", bus.tx_send, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_active", active, 0);
        step(); reset_n = 1'b1;
        vld[1] = 1'b1; dat[1] = 8'h99; drive();
        run_until_sent(base + 2, 40, "mid_after");
        check("mid_after_byte", sent_log[base + 1], 8'h99);
        check("mid_after_fall", send_cyc - fall_cyc, 2);
        run_until_idle(40, "mid");

        // randomized traffic against the round-robin reference
        base = n_sent; g0 = n_grants;
        rand_on = 1'b1; rand_frame = 1'b1;
        for (int i = 0; i < N; i++) gen_left[i] = 6;
        k = 0; left = 24;
        while ((left > 0 || vld != '0 || active || busy || rise_at > cyc) && k < 3000) begin
            step();
            k++;
            left = 0;
            for (int i = 0; i < N; i++) left += gen_left[i];
        end
        check("rand_budget", 32'(k < 3000), 32'd1);
        check("rand_sent", n_sent - base, 24);
        check("rand_grants", n_grants - g0, 24);
        rand_on = 1'b0; rand_frame = 1'b0;

`ifdef TXARB_TIMEOUT_EN
        // transmitter never responds
        base = n_sent;
        tx_dead = 1'b1;
        vld[0] = 1'b1; dat[0] = 8'hE1; drive();
        run_until_sent(base + 1, 30, "to_send");
        k = 0;
        while (timeout_err !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("to_delay", cyc - send_cyc, 17);
        check("to_active", active, 0);
        tx_dead = 1'b0;
        vld[1] = 1'b1; dat[1] = 8'hE2; drive();
        run_until_sent(base + 2, 40, "to_next");
        check("to_next_byte", sent_log[base + 1], 8'hE2);
        check("to_sticky", timeout_err, 1);
        run_until_idle(40, "to");
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
